// File: rtl/operand_wr_arbiter.sv
// Write-port arbiter for the A/B matrix operand buffers.
// Shares one registered row-write port between a single-row bus writer and a
// streaming row loader, and freezes all writes while the engine reads operands.
module operand_wr_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_DIM    = 4,
    localparam int ADDR_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
    localparam int ROW_W      = DATA_WIDTH * MAX_DIM
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // bus single-row writer
    input  logic              bus_req_i,
    input  logic              bus_sel_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [ROW_W-1:0]  bus_data_i,
    input  logic [MAX_DIM-1:0] bus_strb_i,
    output logic              bus_gnt_o,
    // streaming row loader
    input  logic              ld_req_i,
    input  logic              ld_sel_i,
    input  logic [ADDR_W:0]   ld_rows_i,
    input  logic              ld_valid_i,
    input  logic [ROW_W-1:0]  ld_data_i,
    output logic              ld_ready_o,
    output logic              ld_done_o,
    // compute engine
    input  logic              eng_busy_i,
    // operand buffer write port
    output logic              op_a_ien_o,
    output logic              op_b_ien_o,
    output logic [ADDR_W-1:0] op_addr_o,
    output logic [ROW_W-1:0]  op_din_o,
    output logic [MAX_DIM-1:0] op_pstrb_o,
    output logic              arb_busy_o
);

    localparam logic [ADDR_W:0] MAX_ROWS = (ADDR_W + 1)'(MAX_DIM);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_LOAD, S_DONE} state_t;

    state_t             r_state, w_nxt;
    logic               r_last_ld;     // 1: loader won the last grant
    logic               r_sel;         // latched burst target
    logic [ADDR_W:0]    r_rows;
    logic [ADDR_W:0]    r_row_cnt;
    logic               r_a_ien, r_b_ien;
    logic [ADDR_W-1:0]  r_addr;
    logic [ROW_W-1:0]   r_din;
    logic [MAX_DIM-1:0] r_pstrb;

    logic               w_take_bus, w_take_ld, w_accept, w_last;
    logic [ADDR_W:0]    w_rows_clamp, w_cnt_nxt;

    assign w_rows_clamp = (ld_rows_i > MAX_ROWS) ? MAX_ROWS : ld_rows_i;
    assign w_cnt_nxt    = r_row_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last       = (w_cnt_nxt == r_rows);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    // Next state and grant decision; on contention the previous loser wins
    always_comb begin
        w_nxt      = r_state;
        w_take_bus = 1'b0;
        w_take_ld  = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!eng_busy_i) begin
                    if (bus_req_i && (!ld_req_i || r_last_ld)) begin
                        w_take_bus = 1'b1;
                        w_nxt      = S_BUS;
                    end else if (ld_req_i) begin
                        w_take_ld = 1'b1;
                        w_nxt     = (w_rows_clamp == '0) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_BUS:  w_nxt = S_IDLE;
            S_LOAD: begin
                if (ld_valid_i && !eng_busy_i) begin
                    w_accept = 1'b1;
                    if (w_last) w_nxt = S_DONE;
                end
            end
            S_DONE: w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Registered write port, burst bookkeeping and fairness bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_ld <= 1'b1;
            r_sel     <= 1'b0;
            r_rows    <= '0;
            r_row_cnt <= '0;
            r_a_ien   <= 1'b0;
            r_b_ien   <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_pstrb   <= '0;
        end else begin
            r_a_ien <= 1'b0;
            r_b_ien <= 1'b0;
            if (w_take_bus) begin
                r_a_ien   <= !bus_sel_i;
                r_b_ien   <= bus_sel_i;
                r_addr    <= bus_addr_i;
                r_din     <= bus_data_i;
                r_pstrb   <= bus_strb_i;
                r_last_ld <= 1'b0;
            end
            if (w_take_ld) begin
                r_sel     <= ld_sel_i;
                r_rows    <= w_rows_clamp;
                r_row_cnt <= '0;
                r_last_ld <= 1'b1;
            end
            if (w_accept) begin
                r_a_ien   <= !r_sel;
                r_b_ien   <= r_sel;
                r_addr    <= r_row_cnt[ADDR_W-1:0];
                r_din     <= ld_data_i;
                r_pstrb   <= '1;
                r_row_cnt <= w_cnt_nxt;
            end
        end
    end

    assign ld_ready_o = (r_state == S_LOAD) && !eng_busy_i;
    assign bus_gnt_o  = (r_state == S_BUS);
    assign ld_done_o  = (r_state == S_DONE);
    assign arb_busy_o = (r_state != S_IDLE);
    assign op_a_ien_o = r_a_ien;
    assign op_b_ien_o = r_b_ien;
    assign op_addr_o  = r_addr;
    assign op_din_o   = r_din;
    assign op_pstrb_o = r_pstrb;

endmodule

// File: tb/tb_operand_wr_arbiter.sv
// Directed bench for operand_wr_arbiter: bus write, bursts, contention,
// engine stall, row clamping and asynchronous reset mid-burst.
module tb_operand_wr_arbiter;

    localparam int DW = 8;
    localparam int MD = 4;
    localparam int AW = 2;
    localparam int RW = DW * MD;

    logic          clk, rst;
    logic          bus_req, bus_sel, bus_gnt;
    logic [AW-1:0] bus_addr;
    logic [RW-1:0] bus_data;
    logic [MD-1:0] bus_strb;
    logic          ld_req, ld_sel, ld_valid, ld_ready, ld_done;
    logic [AW:0]   ld_rows;
    logic [RW-1:0] ld_data;
    logic          eng_busy;
    logic          a_ien, b_ien, arb_busy;
    logic [AW-1:0] op_addr;
    logic [RW-1:0] op_din;
    logic [MD-1:0] op_pstrb;

    int total = 0;
    int bad   = 0;

    operand_wr_arbiter #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut (
        .clk_i(clk), .rst_i(rst),
        .bus_req_i(bus_req), .bus_sel_i(bus_sel), .bus_addr_i(bus_addr),
        .bus_data_i(bus_data), .bus_strb_i(bus_strb), .bus_gnt_o(bus_gnt),
        .ld_req_i(ld_req), .ld_sel_i(ld_sel), .ld_rows_i(ld_rows),
        .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
        .ld_done_o(ld_done), .eng_busy_i(eng_busy),
        .op_a_ien_o(a_ien), .op_b_ien_o(b_ien), .op_addr_o(op_addr),
        .op_din_o(op_din), .op_pstrb_o(op_pstrb), .arb_busy_o(arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus_req = 0; bus_sel = 0; bus_addr = '0; bus_data = '0; bus_strb = '0;
        ld_req = 0; ld_sel = 0; ld_rows = '0; ld_valid = 0; ld_data = '0;
        eng_busy = 0;
        tick(); tick();
        chk("rst_a_ien", a_ien, 0);  chk("rst_b_ien", b_ien, 0);
        chk("rst_addr", op_addr, 0); chk("rst_din", op_din, 0);
        chk("rst_pstrb", op_pstrb, 0); chk("rst_busy", arb_busy, 0);
        chk("rst_gnt", bus_gnt, 0);  chk("rst_done", ld_done, 0);
        chk("rst_ready", ld_ready, 0);
        rst = 1'b0;

        // 1: single bus write to A
        bus_req = 1; bus_sel = 0; bus_addr = 2'd2; bus_data = 32'h44332211; bus_strb = 4'b0101;
        tick();
        chk("t1_gnt", bus_gnt, 1);     chk("t1_a_ien", a_ien, 1);
        chk("t1_b_ien", b_ien, 0);     chk("t1_addr", op_addr, 2);
        chk("t1_din", op_din, 32'h44332211); chk("t1_pstrb", op_pstrb, 4'b0101);
        chk("t1_busy", arb_busy, 1);
        bus_req = 0;
        tick();
        chk("t1_gnt_off", bus_gnt, 0); chk("t1_ien_off", a_ien, 0);
        chk("t1_addr_hold", op_addr, 2); chk("t1_idle", arb_busy, 0);

        // 2: 4-row burst into B
        ld_req = 1; ld_sel = 1; ld_rows = 3'd4; ld_valid = 1; ld_data = 32'h10;
        tick();
        chk("t2_ready", ld_ready, 1);  chk("t2_no_ien", b_ien, 0);
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'(16 + i);
            tick();
            chk("t2_b_ien", b_ien, 1);  chk("t2_a_ien", a_ien, 0);
            chk("t2_addr", op_addr, 64'(i)); chk("t2_din", op_din, 64'(16 + i));
            chk("t2_pstrb", op_pstrb, 4'hF);
            chk("t2_done", ld_done, (i == 3) ? 1 : 0);
        end
        ld_req = 0; ld_valid = 0;
        tick();
        chk("t2_done_off", ld_done, 0); chk("t2_ien_off", b_ien, 0);
        chk("t2_idle", arb_busy, 0);

        // 3: contention alternation (loader won last -> bus first)
        bus_req = 1; bus_sel = 1; bus_addr = 2'd1; bus_data = 32'hAABBCCDD; bus_strb = 4'hF;
        ld_req = 1; ld_sel = 0; ld_rows = 3'd1; ld_valid = 0;
        tick();
        chk("t3_bus_first", bus_gnt, 1); chk("t3_b_ien", b_ien, 1);
        chk("t3_addr", op_addr, 1);
        tick();
        chk("t3_back_idle", arb_busy, 0);
        tick();
        chk("t3_ld_wins_gnt", bus_gnt, 0); chk("t3_ld_wins_busy", arb_busy, 1);
        chk("t3_ld_ready", ld_ready, 1);
        ld_valid = 1; ld_data = 32'h55;
        tick();
        chk("t3_ld_done", ld_done, 1); chk("t3_a_ien", a_ien, 1);
        chk("t3_ld_addr", op_addr, 0); chk("t3_ld_din", op_din, 32'h55);
        ld_req = 0; ld_valid = 0;
        tick();
        chk("t3_done_off", ld_done, 0);
        tick();
        chk("t3_bus_next", bus_gnt, 1);
        tick();
        // bus won last -> loader wins; rows=0 goes straight to DONE
        ld_req = 1; ld_rows = 3'd0;
        tick();
        chk("t5_zero_done", ld_done, 1); chk("t5_zero_gnt", bus_gnt, 0);
        chk("t5_zero_a", a_ien, 0);      chk("t5_zero_b", b_ien, 0);
        ld_req = 0;
        tick();
        tick();
        chk("t3_bus_again", bus_gnt, 1);
        bus_req = 0;
        tick();

        // 5: rows=7 clamps to 4 writes into A
        ld_req = 1; ld_sel = 0; ld_rows = 3'd7; ld_valid = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'(32 + i);
            tick();
            chk("t5_a_ien", a_ien, 1);  chk("t5_addr", op_addr, 64'(i));
            chk("t5_done", ld_done, (i == 3) ? 1 : 0);
        end
        ld_req = 0; ld_valid = 0;
        tick();
        chk("t5_ien_off", a_ien, 0); chk("t5_idle", arb_busy, 0);

        // 4: engine busy for 3 cycles after row 1
        ld_req = 1; ld_sel = 1; ld_rows = 3'd4; ld_valid = 1;
        tick();
        ld_data = 32'h30; tick(); chk("t4_r0", op_addr, 0);
        ld_data = 32'h31; tick(); chk("t4_r1", op_addr, 1); chk("t4_r1_ien", b_ien, 1);
        eng_busy = 1;
        #1 chk("t4_ready_low", ld_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_ien", b_ien, 0); chk("t4_stall_ready", ld_ready, 0);
            chk("t4_stall_done", ld_done, 0);
        end
        eng_busy = 0; ld_data = 32'h32;
        #1 chk("t4_ready_back", ld_ready, 1);
        tick();
        chk("t4_r2", op_addr, 2); chk("t4_r2_din", op_din, 32'h32); chk("t4_r2_ien", b_ien, 1);
        ld_data = 32'h33;
        tick();
        chk("t4_r3", op_addr, 3); chk("t4_r3_din", op_din, 32'h33); chk("t4_r3_done", ld_done, 1);
        ld_req = 0; ld_valid = 0;
        tick();
        chk("t4_idle", arb_busy, 0);

        // 6: async reset mid-burst, then a fresh burst starts at row 0
        ld_req = 1; ld_sel = 0; ld_rows = 3'd4; ld_valid = 1; ld_data = 32'h40;
        tick();
        tick();
        ld_data = 32'h41;
        tick();
        chk("t6_pre_ien", a_ien, 1); chk("t6_pre_addr", op_addr, 1);
        #2 rst = 1;
        #1;
        chk("t6_rst_ien", a_ien, 0);  chk("t6_rst_addr", op_addr, 0);
        chk("t6_rst_din", op_din, 0); chk("t6_rst_busy", arb_busy, 0);
        #1 rst = 0;
        ld_data = 32'h50;
        tick();
        chk("t6_restart", arb_busy, 1);
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'(80 + i);
            tick();
            chk("t6_addr", op_addr, 64'(i)); chk("t6_a_ien", a_ien, 1);
            chk("t6_din", op_din, 64'(80 + i));
        end
        chk("t6_done", ld_done, 1);
        ld_req = 0; ld_valid = 0;
        tick();
        chk("t6_idle", arb_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
